dct_block_scheduler: RTL
========================

Name: dct_block_scheduler

Overview:
- Shares one free-running 8x8 2D DCT core between NUM_REQ pixel-row requesters, for example Y, Cb and Cr block sources.
- Divides time into 8-cycle block slots aligned to the core's internal row counter. Grants a whole block atomically per slot using round-robin, and injects a zero bubble block when no requester is ready.
- Tags each row entering the core and re-attaches that tag to the matching row leaving the core, so downstream logic knows the source and row index.

Parameters:
- NUM_REQ, 3, number of requesters (2..4)
- DATA_WIDTH, 9, signed pixel sample width fed to the core
- OUT_WIDTH, 18, signed coefficient width returned by the core
- DCT_LATENCY, 24, cycles from a row on dct_x to the corresponding coefficient row on dct_z
- ALIGN_DELAY, 10, cycles after reset release before slot 0 / row 0

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset; the same reset drives the DCT core
- req_valid  in  NUM_REQ  requester i has a row available
- req_row  in  NUM_REQ*8*DATA_WIDTH  requester i row; lane i occupies bits [i*8*DATA_WIDTH +: 8*DATA_WIDTH]
- req_ready  out  NUM_REQ  row of requester i consumed this cycle
- dct_x  out  8*DATA_WIDTH  row to the core's x0..x7 inputs
- dct_sof  out  1  high while row 0 of a slot is on dct_x
- dct_z  in  8*OUT_WIDTH  core's z0..z7 outputs
- out_valid  out  1  out_data holds a coefficient row of a real block
- out_src  out  $clog2(NUM_REQ)  requester that owns the row
- out_row  out  3  coefficient row index 0..7
- out_sop / out_eop  out  1  out_row==0 / out_row==7, qualified by out_valid
- out_data  out  8*OUT_WIDTH  dct_z passed through combinationally, aligned with the tag
- err_underrun  out  1  sticky flag: granted requester starved mid-block
- err_clr  in  1  synchronous clear of err_underrun

Behaviour:
- Reset values: all outputs 0; FSM in INIT; slot counter row_cnt=0; round-robin pointer=0; tag pipe all invalid.
- Plain registers only; the async clear applies to every flop.
- FSM states:
  - INIT: counts ALIGN_DELAY cycles, then enters slot-start.
  - BUBBLE: slot with no grant.
  - BUSY: slot with a grant.
- row_cnt increments every cycle outside INIT and wraps 7->0.
- Slot-start decision, made when row_cnt==0 (the cycle INIT exits counts as row_cnt==0):
  - Round-robin over req_valid, starting at the pointer.
  - On a win: enter BUSY, latch grant, set pointer to winner+1 mod NUM_REQ.
  - On no win: enter BUBBLE.
  - The decision is combinational in that cycle, so row 0 is consumed in the same cycle.
- A request arriving at row_cnt!=0 waits for the next boundary.
- BUSY, each row:
  - req_ready[g] = req_valid[g]; all other req_ready bits are 0.
  - dct_x = req_row lane g.
  - If req_valid[g]==0: dct_x=0 and err_underrun<=1; the slot still completes 8 rows and stays tagged as valid.
- BUBBLE: dct_x=0, req_ready=0.
- Both states return to the decision at row_cnt==7 -> 0.
- dct_sof = (state!=INIT) && row_cnt==0.
- Tag pipe:
  - DCT_LATENCY-deep shift register of {active, src, row}.
  - Input: active=1 in BUSY, 0 in INIT/BUBBLE; src=grant; row=row_cnt.
  - Output drives out_valid, out_src and out_row.
- Underrun takes priority over err_clr when both occur in the same cycle: the flag stays 1.
- Reset mid-operation:
  - Outputs drop immediately and the tag pipe is cleared; no partial block is reported.
  - On release, INIT restarts, matching the core's own timer restart.

Optional Feature:
- Macro: DCT_SCHED_STATS_EN.
- Defined: adds outputs stat_blocks (NUM_REQ*16), one 16-bit granted-block counter per requester, and stat_bubbles (16), a bubble-slot counter.
  - Each counter increments at its slot-start decision and saturates at 0xFFFF.
  - All counters clear on reset and on err_clr.
- Not defined: these ports and counters are absent.

Decomposition:
- Package dct_sched_pkg holds:
  - state enum {INIT, BUBBLE, BUSY};
  - tag struct {active, src, row};
  - ROWS_PER_BLOCK=8.
- One sub-module, rr_arbiter: NUM_REQ-wide, registered pointer, update enable, one-hot grant.
- Tag delay line is inline.

Test Plan (defaults):
- Requester 1 valid continuously from reset -> first dct_sof at cycle 10; req_ready[1] high on cycles 10..17; out_valid first at cycle 34 with out_src=1, out_sop; out_eop at cycle 41.
- All three requesters valid continuously -> grants 0,1,2,0,1 in consecutive slots; no bubble slots; out_src follows the same sequence 24 cycles later.
- req_valid[2] rises at row_cnt=3 of a bubble slot -> no req_ready until the next row_cnt=0; dct_x stays 0 for the remaining 5 rows of the bubble slot.
- Requester 0 granted, req_valid[0] low at row 5 -> dct_x=0 and req_ready[0]=0 that cycle; err_underrun=1 and stays 1 until err_clr; out_valid still shows 8 rows for the block.
- rst_n asserted at row 4 of a BUSY slot -> req_ready, out_valid and err_underrun become 0 immediately; after release, next dct_sof comes 10 cycles later; no out_valid for 34 cycles.
- With DCT_SCHED_STATS_EN: 5 slots, with requester 0 valid only in slots 0 and 2 -> stat_blocks[0]=2, stat_bubbles=3.

Source files
------------

// File: rtl/dct_sched_pkg.sv
// Shared types for the DCT block scheduler: FSM states,
// the per-row tag carried alongside the core, block geometry.
package dct_sched_pkg;

  localparam int ROWS_PER_BLOCK = 8;
  localparam int SRC_MAX_W      = 2;

  typedef enum logic [1:0] {
    INIT,
    BUBBLE,
    BUSY
  } state_t;

  typedef struct packed {
    logic                 active;
    logic [SRC_MAX_W-1:0] src;
    logic [2:0]           row;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: N requests, registered pointer, one-hot grant.
// Ports: clk, rst_n, req, en (advance pointer), gnt (one-hot), any.
module rr_arbiter #(
  parameter int N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic         any
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;
  int           idx;
  int           win;

  always_comb begin
    gnt   = '0;
    any   = 1'b0;
    idx   = 0;
    win   = 0;
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
    if (any) begin
      ptr_d = W'((win + 1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en && any) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dct_block_scheduler.sv
// Shares one free-running 8x8 DCT core between NUM_REQ row sources.
// Ports: clk, rst_n, req_valid/req_row/req_ready (requesters),
//   dct_x/dct_sof/dct_z (core), out_valid/out_src/out_row/
//   out_sop/out_eop/out_data (tagged result), err_underrun, err_clr.
// Optional DCT_SCHED_STATS_EN adds stat_blocks / stat_bubbles.
module dct_block_scheduler
  import dct_sched_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DATA_WIDTH  = 9,
  parameter int OUT_WIDTH   = 18,
  parameter int DCT_LATENCY = 24,
  parameter int ALIGN_DELAY = 10,
  localparam int SRC_W = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*8*DATA_WIDTH-1:0]   req_row,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [8*DATA_WIDTH-1:0]           dct_x,
  output logic                              dct_sof,
  input  logic [8*OUT_WIDTH-1:0]            dct_z,
  output logic                              out_valid,
  output logic [SRC_W-1:0]                  out_src,
  output logic [2:0]                        out_row,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [8*OUT_WIDTH-1:0]            out_data,
  output logic                              err_underrun,
  input  logic                              err_clr
`ifdef DCT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]             stat_blocks,
  output logic [15:0]                       stat_bubbles
`endif
);

  localparam int LW = 8 * DATA_WIDTH;
  localparam int IW = $clog2(ALIGN_DELAY + 1);

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    init_cnt_q;
  logic [2:0]       row_cnt_q;
  logic [SRC_W-1:0] grant_q;
  logic [NUM_REQ-1:0] gnt_oh;
  logic             any;
  logic             slot_start;
  logic [SRC_W-1:0] win_idx;
  logic             cur_busy;
  logic [SRC_W-1:0] cur_grant;
  logic             cur_valid;
  logic             starve;
  tag_t             tag_in;
  tag_t             pipe_q [DCT_LATENCY];

  // The row-0 cycle of every slot makes its grant decision
  // combinationally, so row 0 is consumed in that same cycle.
  assign slot_start = (state_q != INIT) && (row_cnt_q == 3'd0);

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (slot_start),
    .gnt   (gnt_oh),
    .any   (any)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        win_idx = SRC_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: begin
        if (init_cnt_q == IW'(ALIGN_DELAY - 1)) begin
          state_d = BUBBLE;
        end
      end
      BUBBLE, BUSY: begin
        if (slot_start) begin
          state_d = any ? BUSY : BUBBLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // During row 0 the state register still holds the previous
  // slot, so the live decision overrides it.
  always_comb begin
    cur_busy  = slot_start ? any : (state_q == BUSY);
    cur_grant = slot_start ? win_idx : grant_q;
    cur_valid = req_valid[cur_grant];
    req_ready = '0;
    dct_x     = '0;
    if (cur_busy) begin
      req_ready[cur_grant] = cur_valid;
      if (cur_valid) begin
        dct_x = req_row[int'(cur_grant)*LW +: LW];
      end
    end
    starve = cur_busy && !cur_valid;
  end

  assign dct_sof = slot_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      row_cnt_q  <= '0;
      grant_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        init_cnt_q <= init_cnt_q + IW'(1);
      end else begin
        row_cnt_q <= row_cnt_q + 3'd1;
      end
      if (slot_start && any) begin
        grant_q <= win_idx;
      end
    end
  end

  // A starved row in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underrun <= 1'b0;
    end else if (starve) begin
      err_underrun <= 1'b1;
    end else if (err_clr) begin
      err_underrun <= 1'b0;
    end
  end

  always_comb begin
    tag_in        = '0;
    tag_in.active = cur_busy;
    tag_in.src    = SRC_MAX_W'(cur_grant);
    tag_in.row    = row_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DCT_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < DCT_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_valid = pipe_q[DCT_LATENCY-1].active;
  assign out_src   = pipe_q[DCT_LATENCY-1].src[SRC_W-1:0];
  assign out_row   = pipe_q[DCT_LATENCY-1].row;
  assign out_sop   = out_valid && (out_row == 3'd0);
  assign out_eop   = out_valid && (out_row == 3'd7);
  assign out_data  = dct_z;

`ifdef DCT_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] blk_q;
  logic [15:0]              bub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
      bub_q <= '0;
    end else if (err_clr) begin
      blk_q <= '0;
      bub_q <= '0;
    end else if (slot_start) begin
      if (any) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (gnt_oh[i] && blk_q[i] != 16'hFFFF) begin
            blk_q[i] <= blk_q[i] + 16'd1;
          end
        end
      end else if (bub_q != 16'hFFFF) begin
        bub_q <= bub_q + 16'd1;
      end
    end
  end

  assign stat_blocks  = blk_q;
  assign stat_bubbles = bub_q;
`endif

endmodule
